// File: rtl/vid_pkg.sv
// Shared video definitions: pixel slice layout and slot extraction.
// Used by sep2par, par2sep and timing_detec.
package vid_pkg;

    localparam int PIX_W     = 27;
    localparam int HS_BIT    = 26;
    localparam int VS_BIT    = 25;
    localparam int DE_BIT    = 24;
    localparam int MAX_SLOTS = 8;

    // Slot idx of a packed word; slot 0 sits in the low bits.
    function automatic logic [PIX_W-1:0] get_slot(
        input logic [PIX_W*MAX_SLOTS-1:0] word,
        input int                         idx
    );
        return word[idx*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/par2sep_buf.sv
// Two-entry HOLD/PREFETCH word buffer with valid flags and ready.
// Ports: clk, rst_n, din/din_valid/din_ready, sync, pop_last, hold/hold_v.
module par2sep_buf #(
    parameter int W = 54
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         sync,
    input  logic         pop_last,
    output logic [W-1:0] hold,
    output logic         hold_v
);

    logic [W-1:0] pre;
    logic         pre_v;
    logic         wr;

    // Ready depends on registered state only.
    assign din_ready = !pre_v;
    assign wr        = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold   <= '0;
            pre    <= '0;
            hold_v <= 1'b0;
            pre_v  <= 1'b0;
        end else if (sync) begin
            // Realign: drop buffered slots, keep a word landing now.
            pre_v  <= 1'b0;
            hold_v <= wr;
            if (wr)
                hold <= din;
        end else if (pop_last) begin
            // wr implies !pre_v, so these arms are exclusive.
            unique case (1'b1)
                pre_v: begin
                    hold  <= pre;
                    pre_v <= 1'b0;
                end
                wr:      hold   <= din;
                default: hold_v <= 1'b0;
            endcase
        end else if (wr) begin
            if (hold_v) begin
                pre   <= din;
                pre_v <= 1'b1;
            end else begin
                hold   <= din;
                hold_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/par2sep.sv
// Parallel-to-serial pixel unpacker: one packed word in, one pixel/cycle out.
// Ports: clk, rst_n, din/din_valid/din_ready, sync, dout/dout_valid/
// dout_ready, underflow. With PAR2SEP_UNDERFLOW_CNT_EN defined it also
// drives underflow_cnt (saturating) and overflow_err (sticky).
module par2sep
    import vid_pkg::*;
#(
    parameter int SEP_DATA_WIDTH = PIX_W,
    parameter int SHIFT_WIDTH    = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [SEP_DATA_WIDTH*SHIFT_WIDTH-1:0] din,
    input  logic                                din_valid,
    output logic                                din_ready,
    input  logic                                sync,
    output logic [SEP_DATA_WIDTH-1:0]           dout,
    output logic                                dout_valid,
    input  logic                                dout_ready,
`ifdef PAR2SEP_UNDERFLOW_CNT_EN
    output logic [CNT_WIDTH-1:0]                underflow_cnt,
    output logic                                overflow_err,
`endif
    output logic                                underflow
);

    localparam int WW     = SEP_DATA_WIDTH * SHIFT_WIDTH;
    localparam int SLOT_W = $clog2(SHIFT_WIDTH);
    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(SHIFT_WIDTH - 1);

    logic [WW-1:0]     hold;
    logic              hold_v;
    logic [SLOT_W-1:0] slot;
    logic              pix_xfer;
    logic              pop_last;

    assign pix_xfer = hold_v && dout_ready;
    assign pop_last = pix_xfer && (slot == LAST);

    par2sep_buf #(
        .W (WW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sync      (sync),
        .pop_last  (pop_last),
        .hold      (hold),
        .hold_v    (hold_v)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            slot <= '0;
        else if (sync || pop_last)
            slot <= '0;
        else if (pix_xfer)
            slot <= slot + 1'b1;
    end

    assign dout_valid = hold_v;
    assign dout = hold_v ? hold[int'(slot)*SEP_DATA_WIDTH +: SEP_DATA_WIDTH]
                         : '0;
    assign underflow = dout_ready && !hold_v;

`ifdef PAR2SEP_UNDERFLOW_CNT_EN
    logic [5:0] stall_cnt;
    logic       stall;

    assign stall = din_valid && !din_ready;

    always_ff @(posedge clk) begin
        if (!rst_n)
            underflow_cnt <= '0;
        else if (sync)
            underflow_cnt <= '0;
        else if (underflow && !(&underflow_cnt))
            underflow_cnt <= underflow_cnt + 1'b1;
    end

    // Error fires on the 64th consecutive stalled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt    <= '0;
            overflow_err <= 1'b0;
        end else if (!stall) begin
            stall_cnt <= '0;
        end else if (&stall_cnt) begin
            overflow_err <= 1'b1;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_par2sep.sv
// Directed table-driven bench for par2sep (SHIFT_WIDTH = 2).
// Sequences cover streaming, backpressure, starvation, sync and reset.
module tb_par2sep;

    localparam int PW = 27;
    localparam int SW = 2;
    localparam int WW = PW * SW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          sync;
    logic [PW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          underflow;
`ifdef PAR2SEP_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_cnt;
    logic          overflow_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    par2sep #(
        .SEP_DATA_WIDTH (PW),
        .SHIFT_WIDTH    (SW),
        .CNT_WIDTH      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .sync          (sync),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
`ifdef PAR2SEP_UNDERFLOW_CNT_EN
        .underflow_cnt (underflow_cnt),
        .overflow_err  (overflow_err),
`endif
        .underflow     (underflow)
    );

    typedef struct {
        logic          iv;
        int            w;
        logic          dr;
        logic [PW-1:0] ed;
        logic          ev;
        logic          er;
        logic          eu;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [PW-1:0] px(int w, int s);
        return PW'(32'h00A5_0000 + w * 16 + s);
    endfunction

    function automatic logic [WW-1:0] wd(int w);
        return {px(w, 1), px(w, 0)};
    endfunction

    task automatic add(logic iv, int w, logic dr, logic [PW-1:0] ed,
                       logic ev, logic er, logic eu);
        vec_t v;
        v.iv = iv; v.w = w; v.dr = dr;
        v.ed = ed; v.ev = ev; v.er = er; v.eu = eu;
        tbl.push_back(v);
    endtask

    task automatic chk1(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Compares the four observable outputs at the falling edge.
    task automatic chk(string nm, logic [PW-1:0] ed, logic ev,
                       logic er, logic eu);
        @(negedge clk);
        chk1({nm, ".dout"}, dout, ed);
        chk1({nm, ".dout_valid"}, PW'(dout_valid), PW'(ev));
        chk1({nm, ".din_ready"}, PW'(din_ready), PW'(er));
        chk1({nm, ".underflow"}, PW'(underflow), PW'(eu));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic iv, int w, logic dr, logic s);
        din_valid  = iv;
        din        = iv ? wd(w) : '0;
        dout_ready = dr;
        sync       = s;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
        repeat (2) step();
        chk("reset", '0, 1'b0, 1'b1, 1'b0);
`ifdef PAR2SEP_UNDERFLOW_CNT_EN
        chk1("reset.cnt", PW'(underflow_cnt), '0);
        chk1("reset.ovf", PW'(overflow_err), '0);
`endif
        rst_n = 1'b1;
        step();

        // Back-to-back stream W0..W3, then drain to empty.
        add(1, 0, 1, '0,       0, 1, 1);
        add(1, 1, 1, px(0, 0), 1, 1, 0);
        add(1, 2, 1, px(0, 1), 1, 0, 0);
        add(1, 2, 1, px(1, 0), 1, 1, 0);
        add(1, 3, 1, px(1, 1), 1, 0, 0);
        add(1, 3, 1, px(2, 0), 1, 1, 0);
        add(0, 0, 1, px(2, 1), 1, 0, 0);
        add(0, 0, 1, px(3, 0), 1, 1, 0);
        add(0, 0, 1, px(3, 1), 1, 1, 0);
        add(0, 0, 1, '0,       0, 1, 1);
        // Backpressure: two words in, consumer stalled 10 cycles.
        add(1, 4, 0, '0,       0, 1, 0);
        add(1, 5, 0, px(4, 0), 1, 1, 0);
        for (int i = 0; i < 10; i++)
            add(1, 6, 0, px(4, 0), 1, 0, 0);
        add(1, 6, 1, px(4, 0), 1, 0, 0);
        add(1, 6, 1, px(4, 1), 1, 0, 0);
        add(1, 6, 1, px(5, 0), 1, 1, 0);
        add(0, 0, 1, px(5, 1), 1, 0, 0);
        add(0, 0, 1, px(6, 0), 1, 1, 0);
        add(0, 0, 1, px(6, 1), 1, 1, 0);
        add(0, 0, 1, '0,       0, 1, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].w, tbl[i].dr, 1'b0);
            chk($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ev,
                tbl[i].er, tbl[i].eu);
            step();
        end

        // Starvation: word landing with sync is kept, counter cleared.
        drive(1'b1, 7, 1'b0, 1'b1);
        chk("sync_load", '0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("starve_p0", px(7, 0), 1'b1, 1'b1, 1'b0);
        step();
        chk("starve_p1", px(7, 1), 1'b1, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("starve_u%0d", i), '0, 1'b0, 1'b1, 1'b1);
            step();
        end
`ifdef PAR2SEP_UNDERFLOW_CNT_EN
        @(negedge clk);
        chk1("underflow_cnt", PW'(underflow_cnt), PW'(5));
`endif

        // Sync at slot 1 with PREFETCH full; Wn waits then leads.
        drive(1'b1, 8, 1'b0, 1'b0);
        chk("sy_w8", '0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 9, 1'b1, 1'b0);
        chk("sy_w9", px(8, 0), 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 10, 1'b1, 1'b1);
        chk("sy_pulse", px(8, 1), 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 10, 1'b0, 1'b0);
        chk("sy_after", '0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("sy_wn0", px(10, 0), 1'b1, 1'b1, 1'b0);
        step();
        chk("sy_wn1", px(10, 1), 1'b1, 1'b1, 1'b0);
        step();
        chk("sy_empty", '0, 1'b0, 1'b1, 1'b1);
        step();

        // Reset mid-word with PREFETCH full.
        drive(1'b1, 11, 1'b0, 1'b0);
        step();
        drive(1'b1, 12, 1'b1, 1'b0);
        step();
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("rst_pre", px(11, 1), 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_post", '0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 13, 1'b0, 1'b0);
        step();
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("rst_r0", px(13, 0), 1'b1, 1'b1, 1'b0);
        step();
        chk("rst_r1", px(13, 1), 1'b1, 1'b1, 1'b0);
        step();
        chk("rst_end", '0, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/par2sep.md
Name: par2sep

Overview:
- Single-clock parallel-to-serial pixel unpacker; the reverse of sep2par.
- Accepts words of SHIFT_WIDTH packed pixels, each pixel {hs,vs,de,r,g,b}, and emits one pixel per cycle.
- Sits between a wide frame-buffer read path and pixel-rate consumers: timing_detec, or output to the panel.
- A two-word buffer absorbs upstream gaps; an optional counter reports underflows.

Parameters:
- SEP_DATA_WIDTH, 27, width of one pixel slice: {hs,vs,de,r[7:0],g[7:0],b[7:0]}.
- SHIFT_WIDTH, 2, pixels per packed word; legal range 2..8.
- CNT_WIDTH, 16, width of underflow counter (optional feature only).

Ports:
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- din  in  SEP_DATA_WIDTH*SHIFT_WIDTH  packed word; slot 0 = din[SEP_DATA_WIDTH-1:0], emitted first.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  block can accept a word this cycle.
- sync  in  1  single-cycle realign pulse, e.g. vs rising edge.
- dout  out  SEP_DATA_WIDTH  current pixel slice.
- dout_valid  out  1  dout holds a valid pixel.
- dout_ready  in  1  consumer takes dout this cycle.
- underflow  out  1  one-cycle pulse: consumer ready but no pixel available.

Behaviour:
- Handshakes:
  - Word transfer when din_valid && din_ready.
  - Pixel transfer when dout_valid && dout_ready.
  - din may not change while din_valid && !din_ready. The block does not check this.
- Storage:
  - HOLD register (current word) plus slot counter slot[$clog2(SHIFT_WIDTH)-1:0].
  - One PREFETCH word register; valid flags hold_v and pre_v.
- din_ready = !pre_v. This is registered-state only, with no combinational path from dout_ready.
- dout = HOLD slice[slot] when hold_v. dout_valid = hold_v. When !hold_v, dout = 0.
- Slot advance on pixel transfer:
  - If slot != SHIFT_WIDTH-1, increment slot.
  - If slot == SHIFT_WIDTH-1 (last slot), slot wraps to 0. Then:
    - if pre_v, HOLD <= PREFETCH and pre_v <= 0;
    - else if a word arrives this cycle, HOLD <= din;
    - else hold_v <= 0.
- Accepted word routing:
  - If !hold_v, or the last slot is consumed this same cycle and !pre_v, din goes to HOLD.
  - Otherwise din goes to PREFETCH.
- Latency: a word accepted at cycle t into an empty block drives slot 0 on dout at t+1.
- Throughput: one pixel per cycle sustained with din_valid asserted one cycle in every SHIFT_WIDTH.
- Full: hold_v && pre_v → din_ready = 0. It rises the cycle after the last slot of HOLD transfers.
- Empty: hold_v = 0 with dout_ready = 1 → underflow = 1 for that cycle; dout_valid = 0; no state change.
- sync:
  - Clears hold_v and pre_v and sets slot to 0 on the next edge; remaining slots are discarded.
  - A word transferred in the same cycle as sync is kept and loaded into HOLD.
  - sync wins over a simultaneous pixel transfer.
- Reset, including mid-word: hold_v = 0, pre_v = 0, slot = 0, dout = 0, dout_valid = 0, din_ready = 1, underflow = 0, counter = 0. All data registers are cleared.

Optional Feature:
- Macro PAR2SEP_UNDERFLOW_CNT_EN.
- When defined:
  - Adds output underflow_cnt [CNT_WIDTH-1:0], incrementing on every underflow pulse and saturating at all-ones.
  - Cleared by reset and by sync.
  - Adds output overflow_err, 1 bit, sticky. It is set when din_valid is asserted for 64 consecutive cycles with din_ready = 0. It is cleared only by reset.
- When undefined: neither port exists, and the logic is absent.

Decomposition:
- Shared package vid_pkg holds:
  - constants PIX_W = 27, HS_BIT = 26, VS_BIT = 25, DE_BIT = 24;
  - the field-slice function get_slot(word, idx).
  sep2par and timing_detec use the same package.
- One sub-module is natural: par2sep_buf, the two-entry HOLD/PREFETCH word buffer with valid flags and ready logic. The slot mux and counter stay in par2sep.

Test Plan:
- Reset, then feed words W0..W3 back-to-back with din_valid held, dout_ready = 1, SHIFT_WIDTH = 2. Required:
  - dout is W0[26:0], W0[53:27], W1[26:0], ... on consecutive cycles, starting 1 cycle after the W0 transfer;
  - dout_valid is never low;
  - din_ready toggles as expected.
- Hold dout_ready = 0 for 10 cycles after 2 words are accepted. Required:
  - din_ready = 0 from the cycle after the second transfer;
  - dout is stable at W0 slot 0;
  - no data is lost when dout_ready is released.
- Starve din after W0. Required:
  - after 2 pixels, dout_valid = 0 and underflow pulses every cycle;
  - with the macro defined, underflow_cnt = 5 after 5 starved cycles.
- Assert sync while HOLD is at slot 1 with PREFETCH full, together with a new word Wn. Required:
  - the next dout is Wn slot 0;
  - the old slots never appear.
- Deassert rst_n mid-word for one cycle. Required:
  - the next cycle shows dout = 0, dout_valid = 0, din_ready = 1;
  - normal streaming resumes from the next word accepted.
- Drive a color_bar_rgb stream packed by sep2par (1200x1920 timing), unpacked by par2sep, into timing_detec. Required: timing_detec reports HSP = 8, HBP = 46, HFP = 44, h_active = 1200, v_active = 1920.
